muldiv_unit: RTL and testbench

//  Execute-stage iterative multiply/divide unit with architectural HI/LO registers.

---
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider with HI/LO registers.
// Define MULDIV_SIGNED_EN for signed MULT/DIV; the default build is unsigned.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic             hien,
    input  logic             loen,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_MFHI = 4'b1010;
    localparam logic [3:0] OP_MFLO = 4'b1011;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_n;

    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   low;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               divzero;
    logic               accept;
    logic [WIDTH-1:0]   a_mag, b_mag;

    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     div_sh, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
    logic sa, sb;
    always_comb begin
        a_mag = a[WIDTH-1] ? ('0 - a) : a;
        b_mag = b[WIDTH-1] ? ('0 - b) : b;
    end
`else
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    always_comb begin
        accept = start & hien & loen & ~flush & (state == IDLE) &
                 ((alucontrol == OP_MULT) | (alucontrol == OP_DIV));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = RUN;
            RUN: begin
                if (flush)          state_n = IDLE;
                else if (cnt == '0) state_n = FIN;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        rdata = '0;
        if (alucontrol == OP_MFHI)      rdata = hi;
        else if (alucontrol == OP_MFLO) rdata = lo;
    end

    // One iteration step: multiply adds into the upper half and shifts the
    // pair right; divide shifts the pair left and keeps the difference if it fits.
    always_comb begin
        mult_sum = acc + (low[0] ? {1'b0, opnd} : '0);
        div_sh   = {acc[WIDTH-1:0], low[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd};
        div_ge   = (div_sh >= {1'b0, opnd});
    end

    always_comb begin
        prod = {acc[WIDTH-1:0], low};
        quot = low;
        rem  = acc[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
        if (sa ^ sb) begin
            prod = '0 - prod;
            quot = '0 - quot;
        end
        if (sa) rem = '0 - rem;
`endif
        // Remainder already equals a after sign fix; only the quotient is forced.
        if (divzero) quot = '1;
        if (is_div) begin
            res_hi = rem;
            res_lo = quot;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            acc     <= '0;
            low     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            divzero <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sa      <= 1'b0;
            sb      <= 1'b0;
`endif
        end else begin
            done <= (state == FIN) && !flush;
            if (accept) begin
                cnt     <= CW'(WIDTH - 1);
                acc     <= '0;
                low     <= a_mag;
                opnd    <= b_mag;
                is_div  <= (alucontrol == OP_DIV);
                divzero <= (b == '0);
`ifdef MULDIV_SIGNED_EN
                sa      <= a[WIDTH-1];
                sb      <= b[WIDTH-1];
`endif
            end else if (state == RUN) begin
                cnt <= cnt - 1'b1;
                if (is_div) begin
                    acc <= div_ge ? div_diff : div_sh;
                    low <= {low[WIDTH-2:0], div_ge};
                end else begin
                    acc <= {1'b0, mult_sum[WIDTH:1]};
                    low <= {mult_sum[0], low[WIDTH-1:1]};
                end
            end else if ((state == FIN) && !flush) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO, a monitor
// compares them whenever done pulses.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, start, hien, loen, flush;
    logic [3:0]  alucontrol;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo, rdata;

    typedef struct {
        logic [31:0] ehi;
        logic [31:0] elo;
        string       nm;
    } exp_t;

    exp_t expq[$];
    int   nchk  = 0;
    int   nfail = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .alucontrol(alucontrol),
        .hien(hien), .loen(loen), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (expq.size() == 0) begin
                    check("spurious_done", 64'(done), 64'd0);
                end else begin
                    e = expq.pop_front();
                    check({e.nm, "_hi"}, 64'(hi), 64'(e.ehi));
                    check({e.nm, "_lo"}, 64'(lo), 64'(e.elo));
                end
            end
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ehi, input logic [31:0] elo, input string nm);
        int unsigned cyc;
        exp_t e;
        @(negedge clk);
        start = 1'b1; alucontrol = op; hien = 1'b1; loen = 1'b1; a = av; b = bv;
        e.ehi = ehi; e.elo = elo; e.nm = nm;
        expq.push_back(e);
        @(negedge clk);
        start = 1'b0; alucontrol = 4'b1011; a = $urandom; b = $urandom;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check({nm, "_busy_cycles"}, 64'(cyc), 64'd33);
        check({nm, "_done"}, 64'(done), 64'd1);
        check({nm, "_mflo"}, 64'(rdata), 64'(elo));
        alucontrol = 4'b1010;
        #1;
        check({nm, "_mfhi"}, 64'(rdata), 64'(ehi));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc;
        reset = 1'b1; start = 1'b0; hien = 1'b0; loen = 1'b0; flush = 1'b0;
        alucontrol = 4'b1011; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        reset = 1'b0;

        run_op(4'b1000, 32'd7, 32'd6, 32'd0, 32'd42, "mult_7x6");
        run_op(4'b1001, 32'd100, 32'd7, 32'd2, 32'd14, "div_100_7");
        run_op(4'b1001, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, "div_by_zero");
        run_op(4'b1001, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, "div_by_zero_hi");
`ifdef MULDIV_SIGNED_EN
        run_op(4'b1000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "smult_m3x5");
        run_op(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, "smult_m1xm1");
        run_op(4'b1001, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "sdiv_m7_2");
        run_op(4'b1001, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, "sdiv_overflow");
`else
        run_op(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, "umult_max");
        run_op(4'b1001, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, "udiv_big");
        run_op(4'b1001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, "udiv_small_q");
`endif

        // Requests that must not start an operation.
        @(negedge clk);
        start = 1'b1; alucontrol = 4'b1000; hien = 1'b0; loen = 1'b1; a = 32'd3; b = 32'd3;
        @(negedge clk);
        check("ignore_no_hien_busy", 64'(busy), 64'd0);
        hien = 1'b1; alucontrol = 4'b1010;
        @(negedge clk);
        check("ignore_mfhi_busy", 64'(busy), 64'd0);
        alucontrol = 4'b1000; flush = 1'b1;
        @(negedge clk);
        check("flush_blocks_accept", 64'(busy), 64'd0);
        start = 1'b0; flush = 1'b0;

        // Flush mid-multiply: HI/LO keep the previous result.
        run_op(4'b1001, 32'h451, 32'h20, 32'h11, 32'h22, "div_preset");
        @(negedge clk);
        start = 1'b1; alucontrol = 4'b1000; a = 32'd1000; b = 32'd1000;
        @(negedge clk);
        start = 1'b0; alucontrol = 4'b1011;
        for (int i = 1; i < 10; i++) begin
            if (i == 3) begin
                start = 1'b1; alucontrol = 4'b1000; a = 32'd9; b = 32'd9;
            end else begin
                start = 1'b0; alucontrol = 4'b1011;
            end
            @(negedge clk);
        end
        check("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_after", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_hi", 64'(hi), 64'h11);
        check("flush_lo", 64'(lo), 64'h22);
        cyc = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) cyc++;
        end
        check("no_queued_start", 64'(cyc), 64'd0);

        // Reset mid-divide.
        @(negedge clk);
        start = 1'b1; alucontrol = 4'b1001; a = 32'd50; b = 32'd3;
        @(negedge clk);
        start = 1'b0; alucontrol = 4'b1011;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        run_op(4'b1000, 32'd3, 32'd3, 32'd0, 32'd9, "mult_after_reset");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(expq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
